// File: rtl/logic_pipe.sv
// Bitwise logic unit with an elastic STAGES-deep valid/ready pipeline and transfer counter.
// Latency: result visible STAGES cycles after acceptance (STAGES-1 edges after the capture edge).
// Backpressure: each stage holds while downstream is stalled; bubbles collapse, full rate when out_ready is high.
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   in_valid / in_ready  upstream handshake for operands a, b and op
//   out_valid / out_ready downstream handshake for y, y_zero, y_ones
//   xfer_count           saturating count of completed output transfers
module logic_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_ones,
    output logic [15:0]      xfer_count
);

    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  y_q [STAGES];
    logic [STAGES-1:0] zero_q;
    logic [STAGES-1:0] ones_q;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;

    logic [WIDTH-1:0]  res_d;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] up_z;
    logic [STAGES-1:0] up_o;
    logic [WIDTH-1:0]  up_y [STAGES];

    // Stage 1 combinational operation.
    always_comb begin
        res_d = '0;
        case (op)
            3'b000: res_d = a & b;
            3'b001: res_d = a | b;
            3'b010: res_d = a ^ b;
            3'b011: res_d = ~(a & b);
            3'b100: res_d = ~(a | b);
            3'b101: res_d = ~(a ^ b);
            3'b110: res_d = a & ~b;
            3'b111: res_d = a;
            default: res_d = '0;
        endcase
    end

    // Ready chain r_k = !v_k || r_(k+1), unrolled from the output end as
    // "out_ready, or some stage from k onward is empty" so no bit of rdy
    // depends on another bit of rdy.
    always_comb begin
        logic full;
        full = 1'b1;
        rdy  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full   = full & v_q[k];
            rdy[k] = out_ready || !full;
        end
    end

    // Upstream view of every stage: stage 1 sees the input port, others the previous stage.
    always_comb begin
        up_v    = '0;
        up_z    = '0;
        up_o    = '0;
        up_v[0] = in_valid;
        up_y[0] = res_d;
        up_z[0] = (res_d == '0);
        up_o[0] = &res_d;
        for (int k = 1; k < STAGES; k++) begin
            up_v[k] = v_q[k-1];
            up_y[k] = y_q[k-1];
            up_z[k] = zero_q[k-1];
            up_o[k] = ones_q[k-1];
        end
    end

    assign cnt_d = (v_q[STAGES-1] && out_ready && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            zero_q <= '0;
            ones_q <= '0;
            cnt_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                y_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                // Payload loads whenever the stage is ready; an invalid payload is don't-care.
                if (rdy[k]) begin
                    v_q[k]    <= up_v[k];
                    y_q[k]    <= up_y[k];
                    zero_q[k] <= up_z[k];
                    ones_q[k] <= up_o[k];
                end
            end
            cnt_q <= cnt_d;
        end
    end

    assign in_ready   = rdy[0];
    assign out_valid  = v_q[STAGES-1];
    assign y          = y_q[STAGES-1];
    assign y_zero     = zero_q[STAGES-1];
    assign y_ones     = ones_q[STAGES-1];
    assign xfer_count = cnt_q;

endmodule
